// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RISC-V control FSM.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    BOOT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC_R = 4'd7,
    ALUWB  = 4'd8,
    BEQ    = 4'd9,
    TRAP   = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait watchdog: counts consecutive waiting cycles and flags the
// cycle in which the limit is reached. TIMEOUT=0 disables it.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  output logic expire
);

  localparam logic [7:0] LIMIT = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  // Count while waiting; any non-waiting cycle (access done or other state) clears.
  // Saturates so a disabled watchdog never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= 8'd0;
    else if (!waiting)    cnt <= 8'd0;
    else if (cnt != 8'hff) cnt <= cnt + 8'd1;
  end

  assign expire = (TIMEOUT != 0) && waiting && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V main control FSM with memory-wait watchdog and
// sticky illegal-opcode / bus-error flags.
module multicycle_control
  import riscv_mc_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_src,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic [1:0] result_src,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  state_t state_q, state_d;
  logic   waiting, expire;
  logic   set_illegal, set_buserr;

  // Only the three memory-handshake states can stall.
  assign waiting = ((state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR)) && !mem_ready;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .waiting(waiting),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if (set_illegal) illegal <= 1'b1;
      if (set_buserr)  bus_err <= 1'b1;
    end
  end

  // Next state and Moore-style control decode (pc/ir strobes also look at inputs).
  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_src    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    aluop       = ALUOP_ADD;
    result_src  = RES_ALUOUT;
    set_illegal = 1'b0;
    set_buserr  = 1'b0;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_FOUR;
        aluop     = ALUOP_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (expire) begin
          state_d    = TRAP;
          set_buserr = 1'b1;
        end
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        aluop     = ALUOP_ADD;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXEC_R;
          OP_BRANCH:         state_d = BEQ;
          default: begin
            state_d     = TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        aluop     = ALUOP_ADD;
        state_d   = (opcode == OP_LOAD) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req  = 1'b1;
        addr_src = 1'b1;
        if (mem_ready) state_d = MEMWB;
        else if (expire) begin
          state_d    = TRAP;
          set_buserr = 1'b1;
        end
      end
      MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_src = 1'b1;
        if (mem_ready) state_d = FETCH;
        else if (expire) begin
          state_d    = TRAP;
          set_buserr = 1'b1;
        end
      end
      EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        aluop     = ALUOP_FUNCT;
        state_d   = ALUWB;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_d    = FETCH;
      end
      BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        aluop      = ALUOP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = zero;
        state_d    = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = BOOT;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class,
// watchdog expiry/boundary, illegal trap and asynchronous reset.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, mem_req, mem_we, addr_src, reg_write;
  logic [1:0] alu_src_a, alu_src_b, aluop, result_src;
  logic       illegal, bus_err;
  logic [3:0] state;

  int ntests = 0;
  int nfail  = 0;

  localparam logic [3:0] S_BOOT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                         S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC_R = 4'd7,
                         S_ALUWB = 4'd8, S_BEQ = 4'd9, S_TRAP = 4'd10;

  multicycle_control #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_req(mem_req), .mem_we(mem_we),
    .addr_src(addr_src), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .aluop(aluop), .result_src(result_src),
    .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset across an edge, release, and confirm BOOT then FETCH.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_state", state, S_BOOT);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("boot_after_release", state, S_BOOT);
    step();
    chk("fetch_after_boot", state, S_FETCH);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_state0", state, S_BOOT);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_buserr", bus_err, 1'b0);
    chk("rst_memreq", mem_req, 1'b0);
    mem_ready = 1'b1;
    do_reset();

    // R-type
    opcode = 7'b0110011;
    #1;
    chk("f_memreq", mem_req, 1'b1);
    chk("f_irw", ir_write, 1'b1);
    chk("f_pcw", pc_write, 1'b1);
    chk("f_srcb", alu_src_b, 2'b10);
    chk("f_addr", addr_src, 1'b0);
    step(); chk("r_decode", state, S_DECODE);
    chk("d_srca", alu_src_a, 2'b01);
    chk("d_srcb", alu_src_b, 2'b01);
    chk("d_irw", ir_write, 1'b0);
    step(); chk("r_exec", state, S_EXEC_R);
    chk("r_aluop", aluop, 2'b10);
    chk("r_srca", alu_src_a, 2'b10);
    chk("r_regw_exec", reg_write, 1'b0);
    step(); chk("r_aluwb", state, S_ALUWB);
    chk("r_regw", reg_write, 1'b1);
    chk("r_res", result_src, 2'b00);
    step(); chk("r_fetch", state, S_FETCH);
    chk("r_regw_after", reg_write, 1'b0);

    // Load with 3 wait cycles in MEMRD
    opcode = 7'b0000011;
    step(); chk("ld_decode", state, S_DECODE);
    step(); chk("ld_memadr", state, S_MEMADR);
    chk("ld_srca", alu_src_a, 2'b10);
    chk("ld_srcb", alu_src_b, 2'b01);
    step(); mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      chk("ld_memrd", state, S_MEMRD);
      chk("ld_memreq", mem_req, 1'b1);
      chk("ld_addr", addr_src, 1'b1);
      chk("ld_we", mem_we, 1'b0);
      step();
    end
    chk("ld_memwb", state, S_MEMWB);
    chk("ld_regw", reg_write, 1'b1);
    chk("ld_res", result_src, 2'b01);
    chk("ld_memreq_wb", mem_req, 1'b0);
    step(); chk("ld_fetch", state, S_FETCH);

    // Store, zero wait
    opcode = 7'b0100011;
    step(); step(); chk("st_memadr", state, S_MEMADR);
    step(); chk("st_memwr", state, S_MEMWR);
    chk("st_we", mem_we, 1'b1);
    chk("st_req", mem_req, 1'b1);
    chk("st_addr", addr_src, 1'b1);
    step(); chk("st_fetch", state, S_FETCH);

    // BEQ taken and not taken
    opcode = 7'b1100011;
    zero = 1'b1;
    step(); step(); chk("beq_state", state, S_BEQ);
    chk("beq_pcw_taken", pc_write, 1'b1);
    chk("beq_aluop", aluop, 2'b01);
    chk("beq_srcb", alu_src_b, 2'b00);
    step(); chk("beq_fetch1", state, S_FETCH);
    zero = 1'b0;
    step(); step(); chk("beq_state2", state, S_BEQ);
    chk("beq_pcw_nt", pc_write, 1'b0);
    step(); chk("beq_fetch2", state, S_FETCH);

    // Reset mid-store: drop between edges
    opcode = 7'b0100011;
    step(); step(); step();
    mem_ready = 1'b0;
    #1;
    chk("rs_memwr", state, S_MEMWR);
    chk("rs_req_before", mem_req, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("rs_req_drop", mem_req, 1'b0);
    chk("rs_we_drop", mem_we, 1'b0);
    chk("rs_state", state, S_BOOT);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rs_boot", state, S_BOOT);
    step(); chk("rs_fetch", state, S_FETCH);

    // Watchdog expiry in FETCH: 15 waiting cycles then TRAP
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("wd_fetch15", state, S_FETCH);
    chk("wd_buserr_pre", bus_err, 1'b0);
    step();
    chk("wd_trap", state, S_TRAP);
    chk("wd_buserr", bus_err, 1'b1);
    chk("wd_illegal", illegal, 1'b0);

    // Watchdog boundary: ready on the 15th cycle completes normally
    do_reset();
    opcode = 7'b0110011;
    for (int i = 0; i < 14; i++) step();
    mem_ready = 1'b1;
    #1;
    chk("wdb_irw", ir_write, 1'b1);
    step();
    chk("wdb_decode", state, S_DECODE);
    chk("wdb_buserr", bus_err, 1'b0);

    // Illegal opcode
    do_reset();
    opcode = 7'b1110011;
    step(); chk("il_decode", state, S_DECODE);
    step(); chk("il_trap", state, S_TRAP);
    chk("il_flag", illegal, 1'b1);
    chk("il_buserr", bus_err, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("il_strobes", {pc_write, ir_write, mem_req, mem_we, reg_write}, 5'b0);
      chk("il_hold", state, S_TRAP);
      step();
    end
    chk("il_sticky", illegal, 1'b1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter TIMEOUT, default 15: the memory-wait watchdog limit in cycles; legal range 0..255; 0 disables the watchdog.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  7  instruction register bits [6:0]; stable after FETCH completes.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory completion; sampled only while mem_req=1.
REQ-007 pc_write  out  1  PC load strobe.
REQ-008 ir_write  out  1  IR load strobe.
REQ-009 mem_req  out  1  memory access request.
REQ-010 mem_we  out  1  write qualifier for mem_req.
REQ-011 addr_src  out  1  memory address select: 0=PC, 1=ALU-out register.
REQ-012 reg_write  out  1  register-file write strobe.
REQ-013 alu_src_a  out  2  ALU A select: 00=PC, 01=old PC, 10=rs1.
REQ-014 alu_src_b  out  2  ALU B select: 00=rs2, 01=immediate, 10=constant 4.
REQ-015 aluop  out  2  ALU control class: 00=add, 01=sub, 10=funct-decoded.
REQ-016 result_src  out  2  writeback select: 00=ALU-out register, 01=memory data, 10=ALU result.
REQ-017 illegal  out  1  sticky flag for an unsupported opcode.
REQ-018 bus_err  out  1  sticky flag for a watchdog expiry.
REQ-019 state  out  4  current state encoding, for debug.

Function
REQ-020 States: BOOT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, ALUWB, BEQ, TRAP.
REQ-021 Outputs are Moore decodes of the state, except pc_write and ir_write as stated below; every output not listed for a state is 0.
REQ-022 BOOT: all strobes are 0; next state is FETCH unconditionally.
REQ-023 FETCH: mem_req=1, addr_src=0, alu_src_a=00, alu_src_b=10, aluop=00.
REQ-024 FETCH continued: holds until mem_ready=1; in that cycle ir_write=1 and pc_write=1 (PC+4), then next state is DECODE.
REQ-025 DECODE: alu_src_a=01, alu_src_b=01, aluop=00 (branch target).
REQ-026 DECODE transitions by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXEC_R; 1100011 -> BEQ; any other opcode -> TRAP with illegal set.
REQ-027 MEMADR: alu_src_a=10, alu_src_b=01, aluop=00; next state is MEMRD if opcode=0000011, else MEMWR.
REQ-028 MEMRD: mem_req=1, addr_src=1; holds until mem_ready=1, then next state is MEMWB.
REQ-029 MEMWB: result_src=01, reg_write=1; next state is FETCH.
REQ-030 MEMWR: mem_req=1, mem_we=1, addr_src=1; holds until mem_ready=1, then next state is FETCH.
REQ-031 EXEC_R: alu_src_a=10, alu_src_b=00, aluop=10; next state is ALUWB.
REQ-032 ALUWB: result_src=00, reg_write=1; next state is FETCH.
REQ-033 BEQ: alu_src_a=10, alu_src_b=00, aluop=01, result_src=00, pc_write=zero; next state is FETCH.
REQ-034 TRAP: all strobes are 0; the FSM remains in TRAP until reset.
REQ-035 Watchdog: an 8-bit counter increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0, and clears on leaving the state.
REQ-036 Watchdog expiry: if the counter equals TIMEOUT-1 and mem_ready=0, the next state is TRAP and bus_err is set.
REQ-037 Watchdog boundary: mem_ready=1 in that same cycle completes the access normally.
REQ-038 Round-trip counts: R-type takes 4 cycles FETCH->FETCH with zero wait; load 5; store 4; beq 3.

Reset
REQ-039 Asserting reset forces state=BOOT, counter=0, illegal=0 and bus_err=0 immediately, without waiting for a clock edge.
REQ-040 Because of REQ-039, a pending mem_req drops asynchronously; the memory side tolerates an abandoned access.
REQ-041 The first cycle after reset release is BOOT; FETCH follows in the next cycle.

Structure
REQ-042 The shared package riscv_mc_pkg holds the state enum, the opcode constants, the aluop encodings and the alu_src_a, alu_src_b and result_src encodings.
REQ-043 The watchdog counter is the sub-module mem_wait_timer (inputs: clk, reset, waiting, TIMEOUT parameter; output: expire); the rest of the block stays flat.

Verification
REQ-044 R-type: opcode=0110011, mem_ready=1 -> states BOOT, FETCH, DECODE, EXEC_R, ALUWB, FETCH; aluop=10 in EXEC_R; reg_write=1 for exactly 1 cycle.
REQ-045 Load with wait: opcode=0000011, mem_ready=0 for 3 cycles in MEMRD -> mem_req=1 and addr_src=1 for 4 cycles, then MEMWB with reg_write=1 and result_src=01.
REQ-046 BEQ: zero=1 -> pc_write=1 in BEQ; repeat with zero=0 -> pc_write=0; FETCH follows in both cases.
REQ-047 Illegal opcode: opcode=1110011 -> TRAP, illegal=1; over 20 further cycles all strobes stay 0.
REQ-048 Watchdog: TIMEOUT=15, mem_ready=0 in FETCH -> TRAP after 15 waiting cycles with bus_err=1; mem_ready=1 on the 15th cycle -> normal DECODE.
REQ-049 Reset mid-store: assert reset in MEMWR between clock edges -> mem_req and mem_we drop before the next edge; BOOT then FETCH follow after release.
